hilo_mdu_ctrl: RTL and testbench
================================

// Module: hilo_mdu_ctrl
// PURPOSE
//  Sequencer for the HI/LO write port of the register file.
//  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.
//  - Runs an iterative 32-step shift-add multiply or restoring divide.
//  - Stalls the pipeline while busy.
//  - Delivers a single-cycle hi_we/lo_we pulse with data to the register file.
//  - Sits between the EX stage and the regfile hi_we/lo_we/hi_i/lo_i inputs.
// PARAMETERS
//  WIDTH    32            operand width; iteration count = WIDTH
//  DIV0_LO  32'hFFFF_FFFF LO value written on divide-by-zero
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  resetn     in   1   asynchronous active-low reset
//  req_valid  in   1   EX presents an HI/LO operation this cycle
//  req_op     in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others ignored
//  src_a      in   32  rs value (multiplicand / dividend / MTHI-MTLO data)
//  src_b      in   32  rt value (multiplier / divisor)
//  flush      in   1   pipeline flush; aborts an uncommitted operation
//  stall      out  1   hold EX and earlier stages
//  hi_we      out  1   regfile HI write enable, one-cycle pulse
//  lo_we      out  1   regfile LO write enable, one-cycle pulse
//  hi_wdata   out  32  data for HI (drives regfile hi_i)
//  lo_wdata   out  32  data for LO (drives regfile lo_i)
//  div0       out  1   pulses together with the write of a divide by zero
// BEHAVIOUR
//  Reset: resetn=0 forces IDLE immediately; counter and accumulators cleared;
//    stall, hi_we, lo_we, div0 = 0; hi_wdata, lo_wdata = 0.
//  States: IDLE, CALC, FIX, DONE.
//    IDLE/DONE accept a request when req_valid & ~flush.
//  Mul/div accept (cycle T): latch |src_a|, |src_b| (signed ops) or raw (unsigned ops).
//    Latch the result-sign bits. Counter = WIDTH-1. Go to CALC.
//  CALC: one multiply or divide step per cycle for cycles T+1..T+WIDTH.
//    Counter decrements; at 0 go to FIX.
//  FIX (T+WIDTH+1):
//    - Signed multiply: negate the 64-bit product if the operand signs differ.
//    - Signed divide: quotient negative iff operand signs differ; remainder takes the dividend's sign.
//    - Divide-by-zero (src_b==0): override LO=DIV0_LO, HI=src_a unmodified, set div0.
//  DONE (T+WIDTH+2): registered outputs.
//    - hi_we=lo_we=1 for exactly one cycle.
//    - Multiply: HI = product[63:32], LO = product[31:0].
//    - Divide: LO = quotient, HI = remainder.
//  MTHI/MTLO accept at T:
//    - No stall.
//    - T+1 is DONE with only hi_we (MTHI) or only lo_we (MTLO) set; data = src_a.
//  stall = (IDLE|DONE) & req_valid & ~flush & op in {MULT..DIVU}, or state in {CALC, FIX}.
//    - stall is combinational and low in DONE unless a new mul/div is accepted there.
//  DONE: the next state follows the same accept rules as IDLE, so back-to-back operations have no bubble.
//  req_valid while in CALC/FIX is ignored; EX is stalled and re-presents the request.
//  Reserved req_op values (110, 111) are never accepted.
//  flush:
//    - In IDLE/CALC/FIX, flush returns to IDLE next cycle; no write, no div0.
//    - In DONE, flush does not cancel the write (operation committed) and blocks a new accept.
//  Widths: internal product 64 bits, remainder WIDTH+1 bits. Negation is two's complement.
//    0x8000_0000 magnitude handled as unsigned 2^31.
//  Signed overflow (0x8000_0000 / -1): LO=0x8000_0000, HI=0. No flag.
//  we outputs are never asserted outside DONE. Data outputs hold their last value between writes.
// TESTING
//  MULT a=0xFFFFFFFD b=7 at T -> stall T..T+33; T+34 hi_we=lo_we=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//  DIVU a=100 b=7 -> DONE: LO=0x0000000E, HI=0x00000002, div0=0.
//  DIV a=0xFFFFFFF9(-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  DIVU a=5 b=0 -> LO=0xFFFFFFFF, HI=5, div0=1 for one cycle.
//  MTHI 0x12345678 at T -> T+1 hi_we=1, lo_we=0, hi_wdata=0x12345678, stall never high.
//    Then MTLO back-to-back -> lo_we pulse on the next cycle.
//  MULTU started, flush at T+10 -> IDLE at T+11, no we pulse.
//    resetn low at T+20 of a DIV -> all outputs 0 at once; new DIVU after release completes normally.

Source files
------------

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO write-port sequencer: iterative 32-step multiply/divide plus MTHI/MTLO, one-cycle regfile write pulse.
// Mul/div results are written WIDTH+2 cycles after accept with EX stalled; MTHI/MTLO are written the next cycle with no stall.
module hilo_mdu_ctrl #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;      // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;       // multiplier-then-product low half / dividend-then-quotient
  logic [WIDTH-1:0] opb_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_raw_q;
  logic             div_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             bz_q;
  logic             hi_we_q, lo_we_q, div0_q;
  logic [WIDTH-1:0] hi_wdata_q, lo_wdata_q;

  logic             can_accept, acc_md, acc_mt, is_mthi, is_mtlo;
  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] acc_d, lo_d;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0] quo_f, rem_f;

  always_comb begin
    is_mthi    = (req_op == 3'd4);
    is_mtlo    = (req_op == 3'd5);
    can_accept = ((state_q == IDLE) || (state_q == DONE)) && req_valid && !flush;
    acc_md     = can_accept && !req_op[2];
    acc_mt     = can_accept && (is_mthi || is_mtlo);
    stall      = resetn && (acc_md || (state_q == CALC) || (state_q == FIX));

    // Signed ops are 000 (MULT) and 010 (DIV); magnitude of 0x8000_0000 is unsigned 2^31.
    sgn_op = !req_op[0];
    a_neg  = sgn_op && src_a[WIDTH-1];
    b_neg  = sgn_op && src_b[WIDTH-1];
    a_mag  = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag  = b_neg ? (~src_b + 1'b1) : src_b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    acc_d     = acc_q;
    lo_d      = lo_q;
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_d = div_diff[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_shift[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    prod   = {acc_q, lo_q};
    prod_f = neg_q ? (~prod + 1'b1) : prod;
    quo_f  = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_f  = rem_neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      a_raw_q    <= '0;
      div_q      <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      bz_q       <= 1'b0;
      hi_we_q    <= 1'b0;
      lo_we_q    <= 1'b0;
      div0_q     <= 1'b0;
      hi_wdata_q <= '0;
      lo_wdata_q <= '0;
    end else begin
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      div0_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (acc_md) begin
            state_q   <= CALC;
            cnt_q     <= CW'(WIDTH-1);
            acc_q     <= '0;
            div_q     <= req_op[1];
            lo_q      <= req_op[1] ? a_mag : b_mag;
            opb_q     <= req_op[1] ? b_mag : a_mag;
            a_raw_q   <= src_a;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            bz_q      <= (src_b == '0);
          end else if (acc_mt) begin
            state_q <= DONE;
            hi_we_q <= is_mthi;
            lo_we_q <= is_mtlo;
            if (is_mthi) hi_wdata_q <= src_a;
            if (is_mtlo) lo_wdata_q <= src_a;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
            hi_we_q <= 1'b1;
            lo_we_q <= 1'b1;
            if (!div_q) begin
              hi_wdata_q <= prod_f[2*WIDTH-1:WIDTH];
              lo_wdata_q <= prod_f[WIDTH-1:0];
            end else if (bz_q) begin
              hi_wdata_q <= a_raw_q;
              lo_wdata_q <= DIV0_LO;
              div0_q     <= 1'b1;
            end else begin
              hi_wdata_q <= rem_f;
              lo_wdata_q <= quo_f;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi_we    = hi_we_q;
  assign lo_we    = lo_we_q;
  assign div0     = div0_q;
  assign hi_wdata = hi_wdata_q;
  assign lo_wdata = lo_wdata_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboarded directed bench for hilo_mdu_ctrl: expected writes are queued at issue and popped by a write monitor.
`timescale 1ns/1ps
module tb_hilo_mdu_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, hi_we, lo_we, div0;
  logic [31:0] hi_wdata, lo_wdata;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        hw;
    logic        lw;
    logic [31:0] h;
    logic [31:0] l;
    logic        d0;
    int          c;
  } exp_t;

  exp_t sb[$];

  hilo_mdu_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_op   (req_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall    (stall),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .div0     (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && (hi_we || lo_we || div0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: hi_we=%b lo_we=%b div0=%b at cycle %0d, expected no write",
                 hi_we, lo_we, div0, cyc);
      end else begin
        e = sb.pop_front();
        chk("write_cycle", 32'(cyc), 32'(e.c));
        chk("hi_we", 32'(hi_we), 32'(e.hw));
        chk("lo_we", 32'(lo_we), 32'(e.lw));
        chk("div0", 32'(div0), 32'(e.d0));
        if (e.hw) chk("hi_wdata", hi_wdata, e.h);
        if (e.lw) chk("lo_wdata", lo_wdata, e.l);
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hw, input logic lw, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed0, input bit expect_wr, input int flush_at, input int exp_stall);
    int t;
    int st;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
    t = cyc;
    if (expect_wr) sb.push_back('{hw, lw, eh, el, ed0, t + (op[2] ? 1 : 34)});
    @(negedge clk);
    st = int'(stall);
    for (int i = 1; i < 40; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush = (i == flush_at);
      @(negedge clk);
      st += int'(stall);
    end
    flush = 1'b0;
    chk({name, "_stall_cycles"}, 32'(st), 32'(exp_stall));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    int st;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi_we", 32'(hi_we), 32'd0);
    chk("rst_lo_we", 32'(lo_we), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_hi_wdata", hi_wdata, 32'd0);
    chk("rst_lo_wdata", lo_wdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    //       name      op      a             b             hw    lw    HI            LO            d0  wr  fl  stall
    run_op("mult",    3'b000, 32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1, -1, 34);
    run_op("multu",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001, 0, 1, -1, 34);
    run_op("divu",    3'b011, 32'd100,      32'd7,        1'b1, 1'b1, 32'h00000002, 32'h0000000E, 0, 1, -1, 34);
    run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1, -1, 34);
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h80000000, 0, 1, -1, 34);
    run_op("divu_0",  3'b011, 32'd5,        32'd0,        1'b1, 1'b1, 32'h00000005, 32'hFFFFFFFF, 1, 1, -1, 34);
    run_op("div_0",   3'b010, 32'hFFFFFFF9, 32'd0,        1'b1, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 1, -1, 34);
    run_op("rsvd",    3'b110, 32'h11111111, 32'h2,        1'b0, 1'b0, 32'h0,        32'h0,        0, 0, -1, 0);
    run_op("flush",   3'b001, 32'd5,        32'd6,        1'b0, 1'b0, 32'h0,        32'h0,        0, 0, 10, 11);
    run_op("fl_done", 3'b011, 32'd100,      32'd7,        1'b1, 1'b1, 32'h00000002, 32'h0000000E, 0, 1, 34, 34);

    // MTHI then MTLO back-to-back
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'b100; src_a = 32'h12345678;
    t = cyc;
    sb.push_back('{1'b1, 1'b0, 32'h12345678, 32'h0, 1'b0, t + 1});
    @(negedge clk);
    st = int'(stall);
    @(posedge clk); #1;
    req_op = 3'b101; src_a = 32'hCAFEF00D;
    sb.push_back('{1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, t + 2});
    @(negedge clk);
    st += int'(stall);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      st += int'(stall);
    end
    chk("mt_stall_cycles", 32'(st), 32'd0);

    // reset in the middle of a DIV
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'b010; src_a = 32'hFFFFFFF9; src_b = 32'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mid_div_stall", 32'(stall), 32'd1);
    resetn = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_hi_we", 32'(hi_we), 32'd0);
    chk("arst_lo_we", 32'(lo_we), 32'd0);
    chk("arst_div0", 32'(div0), 32'd0);
    chk("arst_hi_wdata", hi_wdata, 32'd0);
    chk("arst_lo_wdata", lo_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    run_op("post_rst", 3'b011, 32'd100, 32'd7, 1'b1, 1'b1, 32'h00000002, 32'h0000000E, 0, 1, -1, 34);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
